// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Instruction-memory request/response bus used by the fetch stage.
//   One request may be outstanding at a time; the response arrives at least
//   one cycle after the grant.
//
//   Signals
//     req     master->slave  request valid
//     addr    master->slave  instruction address (ISIZE)
//     gnt     slave->master  address accepted (meaningful only while req=1)
//     rvalid  slave->master  read response valid
//     rdata   slave->master  instruction word (ISIZE)
//
//   FETCH_ISIZE is the shared default width of addresses and instructions.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

`ifndef FETCH_ISIZE
`define FETCH_ISIZE 16
`endif

interface fetch_stage_if #(
    parameter int ISIZE = `FETCH_ISIZE
);
    logic             req;
    logic [ISIZE-1:0] addr;
    logic             gnt;
    logic             rvalid;
    logic [ISIZE-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Single-outstanding instruction fetch stage feeding a registered IF/ID
//   slot. The PC register lives outside this block: it loads nextPC+1 every
//   cycle, so "hold" is expressed as nextPC = currPC-1 and "advance" as
//   nextPC = currPC.
//
//   Ports
//     clk          clock, all state changes on the rising edge
//     rst          asynchronous, active-low reset
//     currPC       current fetch address from the PC register
//     nextPC       value presented to the PC register
//     imem         instruction-memory bus (fetch_stage_if.master)
//     stall_in     decode cannot accept the slot this cycle
//     redirect_in  branch redirect pulse
//     redirect_pc  redirect target
//     if_valid     IF/ID slot holds an instruction
//     if_instr     IF/ID slot instruction word
//     if_pc        IF/ID slot instruction address
//     fetch_cnt    (FETCH_PERF_CNT_EN only) count of slot writes, wraps
//
//   Configuration
//     FETCH_PERF_CNT_EN  defined: adds the fetch_cnt performance counter.
//                        undefined: no counter and no fetch_cnt port.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module fetch_stage #(
    parameter int ISIZE = `FETCH_ISIZE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ISIZE-1:0] currPC,
    output logic [ISIZE-1:0] nextPC,
    fetch_stage_if.master    imem,
    input  logic             stall_in,
    input  logic             redirect_in,
    input  logic [ISIZE-1:0] redirect_pc,
    output logic             if_valid,
    output logic [ISIZE-1:0] if_instr,
    output logic [ISIZE-1:0] if_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]      fetch_cnt
`endif
);

    localparam logic [ISIZE-1:0] ONE = ISIZE'(1);

    // IDLE: first cycle after reset, parks the PC at address 0.
    // REQ : presents currPC to memory until granted.
    // WAIT: response outstanding, will be written into the slot.
    // DROP: response outstanding but made stale by a redirect.
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DROP
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [ISIZE-1:0] grant_pc_q;   // address accepted by memory
    logic             issue;
    logic             grant;
    logic             slot_wr;

    // -----------------------------------------------------------------------
    // Request side.
    // Only request when the slot is guaranteed empty by the time the
    // response can arrive: either it is empty now or decode takes it at
    // this edge. That is why a response never has to wait for the slot.
    // -----------------------------------------------------------------------
    assign issue     = (state_q == S_REQ) && (!if_valid || !stall_in);
    assign grant     = issue && imem.gnt;
    assign imem.req  = issue;
    assign imem.addr = (state_q == S_REQ) ? currPC : '0;

    // A response is only consumed while WAIT is still the live transaction.
    assign slot_wr = (state_q == S_WAIT) && imem.rvalid && !redirect_in;

    // -----------------------------------------------------------------------
    // PC steering. A redirect wins over everything so the PC register lands
    // exactly on the target on the following cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        if (redirect_in) begin
            nextPC = redirect_pc - ONE;
        end else if (state_q == S_IDLE) begin
            nextPC = '1;
        end else if (grant) begin
            nextPC = currPC;
        end else begin
            nextPC = currPC - ONE;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic.
    // -----------------------------------------------------------------------
    // NOTE: every variable written in an always_comb gets a default on entry;
    // any path that leaves one unassigned would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                state_d = S_REQ;
            end
            S_REQ: begin
                // A grant that coincides with a redirect fetched the wrong
                // address; its response must still be drained.
                if (grant) begin
                    state_d = redirect_in ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                // With rvalid the transaction ends either way; a redirect in
                // the same cycle merely suppresses the slot write.
                if (imem.rvalid) begin
                    state_d = S_REQ;
                end else if (redirect_in) begin
                    state_d = S_DROP;
                end
            end
            S_DROP: begin
                // Further redirects keep us here; only the stale response
                // itself releases the state, otherwise we would wait forever.
                if (imem.rvalid) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            grant_pc_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                grant_pc_q <= currPC;
            end
        end
    end

    // -----------------------------------------------------------------------
    // IF/ID slot.
    // Priority: redirect flush, then a fresh write, then consumption by
    // decode. A stalled slot holds its contents.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= '0;
        end else if (redirect_in) begin
            if_valid <= 1'b0;
        end else if (slot_wr) begin
            if_valid <= 1'b1;
            if_instr <= imem.rdata;
            if_pc    <= grant_pc_q;
        end else if (!stall_in) begin
            if_valid <= 1'b0;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Performance counter: one count per slot write, discarded responses
    // excluded. Wraps naturally at 16 bits.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt <= '0;
        end else if (slot_wr) begin
            fetch_cnt <= fetch_cnt + 16'd1;
        end
    end
`else
    // Counter omitted: slot_wr only drives the IF/ID slot.
`endif

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter ISIZE, default 16 (shared define), width of addresses and instructions.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 currPC  input  ISIZE  current fetch address from the PC register.
REQ-005 nextPC  output  ISIZE  value presented to PC register; PC register loads nextPC+1 each cycle.
REQ-006 imem_req/imem_addr  output  1/ISIZE  instruction-memory request and address.
REQ-007 imem_gnt  input  1  address accepted; meaningful only in cycles with imem_req=1.
REQ-008 imem_rvalid/imem_rdata  input  1/ISIZE  read response; at most one outstanding; arrives >=1 cycle after gnt.
REQ-009 stall_in  input  1  decode cannot accept if_* this cycle.
REQ-010 redirect_in/redirect_pc  input  1/ISIZE  branch redirect pulse and target.
REQ-011 if_valid/if_instr/if_pc  output  1/ISIZE/ISIZE  registered IF/ID slot.

Function
REQ-012 FSM states IDLE, REQ, WAIT, DROP; IDLE -> REQ unconditionally next cycle.
REQ-013 nextPC combinational: IDLE -> 16'hFFFF (PC lands at 0); redirect_in=1 -> redirect_pc-1 (mod 2^ISIZE, overrides all); imem_req&&imem_gnt -> currPC; otherwise currPC-1 (hold).
REQ-014 REQ: imem_addr=currPC; imem_req = !if_valid || !stall_in; req&&gnt&&!redirect -> WAIT.
REQ-015 WAIT: imem_req=0; rvalid&&!redirect -> write if_instr=rdata, if_pc=address granted, if_valid=1, -> REQ.
REQ-016 Slot consumption: if_valid&&!stall_in clears if_valid at edge unless written same edge; if_* hold while stalled.
REQ-017 Issue rule guarantees slot empty at response; rvalid in any state other than WAIT/DROP ignored.
REQ-018 Redirect in REQ: gnt same cycle -> DROP, else stay REQ; in WAIT: rvalid same cycle discarded -> REQ, else -> DROP; in DROP stays DROP.
REQ-019 Redirect clears if_valid next edge regardless of stall_in; no write to slot that cycle.
REQ-020 DROP: imem_req=0; next rvalid discarded, -> REQ.
REQ-021 Steady state without stalls: one instruction per 2 cycles (gnt, rvalid next cycle).

Reset
REQ-022 rst low asynchronously forces IDLE, if_valid=0, if_instr=0, if_pc=0, imem_req=0, imem_addr=0.
REQ-023 Reset mid-transaction abandons outstanding request; late rvalid after release ignored (state not WAIT/DROP).

Configuration
REQ-024 Macro FETCH_PERF_CNT_EN defined: output fetch_cnt[15:0] counts slot writes, reset 0, wraps 16'hFFFF->0, not incremented for discarded responses.
REQ-025 Macro FETCH_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.

Verification
REQ-026 Reset release, gnt immediate, rvalid 1 cycle later, no stall -> if_pc 0,1,2 on if_valid cycles; nextPC 16'hFFFF in IDLE.
REQ-027 stall_in held 4 cycles with if_valid=1, if_pc=5 -> if_* constant, imem_req=0, nextPC=currPC-1; after release fetch of 6 proceeds.
REQ-028 redirect_in with redirect_pc=0x0040 while WAIT, rvalid next cycle -> response discarded, if_valid=0, next if_pc=0x0040.
REQ-029 redirect_in same cycle as rvalid -> if_valid=0 next edge, state REQ, currPC=target next cycle.
REQ-030 rst low while WAIT, rvalid arrives after release -> ignored; if_valid stays 0; fetch_cnt (if enabled) 0, wraps to 0 after 65536 writes.
